// File: rtl/bram_read_arbiter_pkg.sv
// Shared definitions for the parameter-BRAM read arbiter and its loaders.
//   - arb_state_t     : arbiter FSM state encoding
//   - DEFAULT_RD_LAT  : BRAM read latency (address registered -> dout valid)
//   - L1_BIAS_BASE    : BRAM region base used by the layer-1 bias loader
//   - rr_wrap()       : modulo helper for round-robin index arithmetic
package bram_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_RD_LAT = 2;

  localparam logic [17:0] L1_BIAS_BASE = 18'd147520;

  // Wraps an index that is known to be below 2*n back into 0..n-1 without
  // a general divider.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/bram_read_arbiter_if.sv
// Bus bundle between the loader clients, the arbiter and the BRAM read port.
//   Client side : req, req_base, req_len -> arbiter; grant, done, rd_* <- arbiter
//   BRAM side   : bram_en, bram_ren, bram_addr -> BRAM; bram_dout <- BRAM
// Modports:
//   master : the arbiter
//   slave  : the clients plus the BRAM instance (or a testbench standing in)
interface bram_read_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int LEN_WIDTH  = 18
);

  logic [N_REQ-1:0]            req;
  logic [N_REQ*ADDR_WIDTH-1:0] req_base;
  logic [N_REQ*LEN_WIDTH-1:0]  req_len;
  logic [N_REQ-1:0]            grant;
  logic [N_REQ-1:0]            done;
  logic                        rd_valid;
  logic [W-1:0]                rd_data;
  logic [LEN_WIDTH-1:0]        rd_idx;
  logic                        rd_last;
  logic                        bram_en;
  logic                        bram_ren;
  logic [ADDR_WIDTH-1:0]       bram_addr;
  logic [W-1:0]                bram_dout;

  modport master (
    input  req, req_base, req_len, bram_dout,
    output grant, done, rd_valid, rd_data, rd_idx, rd_last,
           bram_en, bram_ren, bram_addr
  );

  modport slave (
    output req, req_base, req_len, bram_dout,
    input  grant, done, rd_valid, rd_data, rd_idx, rd_last,
           bram_en, bram_ren, bram_addr
  );

endinterface

// File: rtl/bram_read_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
// Ports:
//   req        in  N_REQ  request vector
//   last_grant in  IDX_W  index of the most recently granted client
//   win_oh     out N_REQ  one-hot winner (all zero when nobody requests)
//   win_idx    out IDX_W  index of the winner
//   win_valid  out 1      at least one request present
module rr_picker
  import bram_read_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  int cand;

  // Scan starts just after the last winner and wraps, so the previous
  // winner is visited last and therefore has the lowest priority.
  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = rr_wrap(int'(last_grant) + off, N_REQ);
      if (!win_valid && req[IDX_W'(cand)]) begin
        win_valid              = 1'b1;
        win_oh[IDX_W'(cand)]   = 1'b1;
        win_idx                = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: round-robin arbiter and burst sequencer in front of the
// single read-only parameter BRAM. One client at a time gets a burst of
// consecutive addresses; returned words are streamed back with valid, index
// and last markers, followed by a one-cycle done pulse to that client.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    master modport of bram_read_arbiter_if
//            req/req_base/req_len : per-client burst requests
//            grant/done           : one-hot grant, one-cycle done pulse
//            rd_valid/rd_data/rd_idx/rd_last : returned word stream
//            bram_en/bram_ren/bram_addr/bram_dout : BRAM read port
module bram_read_arbiter
  import bram_read_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int LEN_WIDTH  = 18,
  parameter int RD_LAT     = DEFAULT_RD_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_read_arbiter_if.master bus
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int DRAIN_W = $clog2(RD_LAT) + 1;

  arb_state_t            state_q, state_d;
  logic [N_REQ-1:0]      grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;

  logic [RD_LAT-1:0]     vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0]     last_pipe_q, last_pipe_d;
  logic [LEN_WIDTH-1:0]  idx_pipe_q [RD_LAT];
  logic [LEN_WIDTH-1:0]  idx_pipe_d [RD_LAT];

  logic [N_REQ-1:0]      pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic                  issue_fire;
  logic                  issue_last;

  rr_picker #(.N_REQ(N_REQ)) u_rr_picker (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .win_oh     (pick_oh),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // A zero-length burst still spends one cycle in ISSUE so the client sees
  // grant for a cycle, but no address is issued there.
  assign issue_fire = (state_q == ST_ISSUE) && (len_q != '0);
  assign issue_last = (cnt_q == len_q - 1'b1);

  always_comb begin
    state_d      = state_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_oh_d   = pick_oh;
          last_grant_d = pick_idx;
          base_d       = bus.req_base[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          len_d        = bus.req_len[pick_idx*LEN_WIDTH +: LEN_WIDTH];
          cnt_d        = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (issue_last) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        // Wait out the BRAM latency so the final word lands before DONE.
        if (drain_q == DRAIN_W'(RD_LAT - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        grant_oh_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Return-path markers travel alongside the issued address so they line
  // up with bram_dout RD_LAT cycles later. Idle stages carry zeros so that
  // rd_idx/rd_last read 0 whenever rd_valid is low.
  always_comb begin
    vld_pipe_d[0]  = issue_fire;
    last_pipe_d[0] = issue_fire && issue_last;
    idx_pipe_d[0]  = issue_fire ? cnt_q : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
      idx_pipe_d[i]  = idx_pipe_q[i-1];
    end
  end

  // A mid-burst reset abandons the burst outright; the pipeline is cleared
  // so no stale word or done can follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_oh_q   <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      base_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      drain_q      <= '0;
      vld_pipe_q   <= '0;
      last_pipe_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        idx_pipe_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      vld_pipe_q   <= vld_pipe_d;
      last_pipe_q  <= last_pipe_d;
      for (int i = 0; i < RD_LAT; i++) begin
        idx_pipe_q[i] <= idx_pipe_d[i];
      end
    end
  end

  // Outputs decode straight from reset flops, so they all drop to 0 the
  // moment rst_n falls.
  assign bus.grant     = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) ? grant_oh_q : '0;
  assign bus.done      = (state_q == ST_DONE) ? grant_oh_q : '0;
  assign bus.bram_en   = issue_fire || (state_q == ST_DRAIN);
  assign bus.bram_ren  = issue_fire;
  assign bus.bram_addr = issue_fire ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;
  assign bus.rd_valid  = vld_pipe_q[RD_LAT-1];
  assign bus.rd_last   = last_pipe_q[RD_LAT-1];
  assign bus.rd_idx    = idx_pipe_q[RD_LAT-1];
  assign bus.rd_data   = vld_pipe_q[RD_LAT-1] ? bus.bram_dout : '0;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Testbench for bram_read_arbiter: drives directed bursts, models a BRAM
// whose data is the address LSB, and checks returned words against a
// scoreboard of expected words plus grant/done/address timing.
module tb_bram_read_arbiter;
  import bram_read_arbiter_pkg::*;

  localparam int N_REQ  = 4;
  localparam int W      = 8;
  localparam int AW     = 18;
  localparam int LW     = 18;
  localparam int RD_LAT = 2;

  typedef struct {
    int             client;
    logic [LW-1:0]  idx;
    logic [W-1:0]   data;
    logic           last;
  } exp_word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  exp_word_t sb[$];
  exp_word_t mon_e;

  logic [AW-1:0] bram_addr_r;
  logic [W-1:0]  bram_dout_r;

  bram_read_arbiter_if #(
    .N_REQ(N_REQ), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) bus ();

  bram_read_arbiter #(
    .N_REQ(N_REQ), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage BRAM stand-in: address registered, then data registered.
  always @(posedge clk) begin
    if (bus.bram_en && bus.bram_ren) bram_addr_r <= bus.bram_addr;
    bram_dout_r <= bram_addr_r[W-1:0];
  end
  assign bus.bram_dout = bram_dout_r;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Return-stream monitor: every rd_valid must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("grant_onehot0", 64'($onehot0(bus.grant)), 64'd1);
      if (bus.rd_valid) begin
        if (sb.size() == 0) begin
          checkOutput("rd_unexpected_valid", 64'(bus.rd_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("rd_idx", 64'(bus.rd_idx), 64'(mon_e.idx));
          checkOutput("rd_data", 64'(bus.rd_data), 64'(mon_e.data));
          checkOutput("rd_last", 64'(bus.rd_last), 64'(mon_e.last));
          checkOutput("rd_grant", 64'(bus.grant), 64'(1) << mon_e.client);
        end
      end else begin
        checkOutput("rd_idle_data", 64'(bus.rd_data), 64'd0);
        checkOutput("rd_idle_last", 64'(bus.rd_last), 64'd0);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"},    64'(bus.grant),     64'd0);
    checkOutput({tag, "_done"},     64'(bus.done),      64'd0);
    checkOutput({tag, "_rd_valid"}, 64'(bus.rd_valid),  64'd0);
    checkOutput({tag, "_rd_data"},  64'(bus.rd_data),   64'd0);
    checkOutput({tag, "_rd_idx"},   64'(bus.rd_idx),    64'd0);
    checkOutput({tag, "_rd_last"},  64'(bus.rd_last),   64'd0);
    checkOutput({tag, "_bram_en"},  64'(bus.bram_en),   64'd0);
    checkOutput({tag, "_bram_ren"}, 64'(bus.bram_ren),  64'd0);
    checkOutput({tag, "_bram_addr"},64'(bus.bram_addr), 64'd0);
  endtask

  task automatic resetDut();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_base = '0;
    bus.req_len  = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int client, input int base, input int len);
    bus.req_base[client*AW +: AW] = AW'(base);
    bus.req_len[client*LW +: LW]  = LW'(len);
    bus.req[client]               = 1'b1;
  endtask

  task automatic pushBurst(input int client, input int base, input int len);
    exp_word_t     e;
    logic [AW-1:0] a;
    for (int k = 0; k < len; k++) begin
      a        = AW'(base + k);
      e.client = client;
      e.idx    = LW'(k);
      e.data   = a[W-1:0];
      e.last   = (k == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic waitDone(input logic [N_REQ-1:0] exp_oh, input string tag, output int when);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done != '0) break;
    end
    checkOutput(tag, 64'(bus.done), 64'(exp_oh));
    when = cyc;
  endtask

  initial begin
    int t0;
    int tdone;
    int prev;
    int seen [N_REQ];
    int wrap_addr [4];
    logic found;

    bus.req      = '0;
    bus.req_base = '0;
    bus.req_len  = '0;

    // Single client, layer-1 bias region, len 8.
    resetDut();
    $display("[TB] single burst from client 1");
    applyStimulus(1, int'(L1_BIAS_BASE), 8);
    pushBurst(1, 147520, 8);
    t0 = cyc;
    @(negedge clk);
    checkOutput("t1_grant", 64'(bus.grant), 64'b0010);
    checkOutput("t1_addr0", 64'(bus.bram_addr), 64'd147520);
    checkOutput("t1_ren0", 64'(bus.bram_ren), 64'd1);
    bus.req = '0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      checkOutput("t1_addr", 64'(bus.bram_addr), 64'(147520 + k));
      checkOutput("t1_en", 64'(bus.bram_en), 64'd1);
    end
    waitDone(4'b0010, "t1_done", tdone);
    checkOutput("t1_done_cycle", 64'(tdone - t0), 64'd11);
    checkOutput("t1_done_grant_low", 64'(bus.grant), 64'd0);
    @(negedge clk);
    checkOutput("t1_done_one_cycle", 64'(bus.done), 64'd0);
    checkOutput("t1_sb_drained", 64'(sb.size()), 64'd0);

    // Clients 0 and 2 held together.
    resetDut();
    $display("[TB] clients 0 and 2 alternate");
    applyStimulus(0, 100, 4);
    applyStimulus(2, 300, 4);
    pushBurst(0, 100, 4);
    pushBurst(2, 300, 4);
    pushBurst(0, 100, 4);
    pushBurst(2, 300, 4);
    prev = 0;
    for (int b = 0; b < 4; b++) begin
      waitDone((b % 2 == 0) ? 4'b0001 : 4'b0100, "t2_done_order", tdone);
      if (b == 3) bus.req = '0;
      if (b > 0) checkOutput("t2_done_spacing", 64'(tdone - prev), 64'd8);
      prev = tdone;
      @(negedge clk);
      checkOutput("t2_done_one_cycle", 64'(bus.done), 64'd0);
    end
    checkOutput("t2_sb_drained", 64'(sb.size()), 64'd0);

    // All four clients held for eight bursts.
    resetDut();
    $display("[TB] four clients round robin");
    for (int c = 0; c < N_REQ; c++) begin
      applyStimulus(c, 1000 * (c + 1), 2);
      seen[c] = 0;
    end
    for (int b = 0; b < 8; b++) pushBurst(b % 4, 1000 * ((b % 4) + 1), 2);
    for (int b = 0; b < 8; b++) begin
      waitDone(4'(1 << (b % 4)), "t3_done_order", tdone);
      if (b == 7) bus.req = '0;
      for (int c = 0; c < N_REQ; c++) if (bus.done[c]) seen[c]++;
    end
    for (int c = 0; c < N_REQ; c++) checkOutput("t3_grant_count", 64'(seen[c]), 64'd2);
    repeat (2) @(negedge clk);
    checkOutput("t3_sb_drained", 64'(sb.size()), 64'd0);

    // Zero-length burst from client 3.
    resetDut();
    $display("[TB] zero-length burst");
    applyStimulus(3, 500, 0);
    @(negedge clk);
    checkOutput("t4_grant", 64'(bus.grant), 64'b1000);
    checkOutput("t4_ren", 64'(bus.bram_ren), 64'd0);
    checkOutput("t4_en", 64'(bus.bram_en), 64'd0);
    bus.req = '0;
    @(negedge clk);
    checkOutput("t4_done", 64'(bus.done), 64'b1000);
    checkOutput("t4_grant_low", 64'(bus.grant), 64'd0);
    checkOutput("t4_ren_done", 64'(bus.bram_ren), 64'd0);
    @(negedge clk);
    checkOutput("t4_done_one_cycle", 64'(bus.done), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("t4_grant_stays_low", 64'(bus.grant), 64'd0);

    // Address wrap-around at the top of the BRAM.
    resetDut();
    $display("[TB] address wrap");
    wrap_addr = '{262142, 262143, 0, 1};
    applyStimulus(0, 262142, 4);
    pushBurst(0, 262142, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus.req = '0;
      checkOutput("t5_addr", 64'(bus.bram_addr), 64'(wrap_addr[k]));
    end
    waitDone(4'b0001, "t5_done", tdone);
    @(negedge clk);
    checkOutput("t5_sb_drained", 64'(sb.size()), 64'd0);

    // Reset in the middle of a long burst.
    resetDut();
    $display("[TB] reset mid-burst");
    applyStimulus(1, 2000, 16);
    pushBurst(1, 2000, 16);
    @(negedge clk);
    bus.req = '0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.rd_valid && bus.rd_idx == LW'(3)) found = 1'b1;
    end
    checkOutput("t6_reached_word3", 64'(bus.rd_idx), 64'd3);
    #1 rst_n = 1'b0;
    #1 checkAllZero("t6_async");
    sb.delete();
    @(negedge clk);
    checkAllZero("t6_held");
    rst_n = 1'b1;
    applyStimulus(2, 3000, 4);
    pushBurst(2, 3000, 4);
    t0 = cyc;
    @(negedge clk);
    checkOutput("t6_new_grant", 64'(bus.grant), 64'b0100);
    checkOutput("t6_new_addr", 64'(bus.bram_addr), 64'd3000);
    bus.req = '0;
    waitDone(4'b0100, "t6_done", tdone);
    checkOutput("t6_done_cycle", 64'(tdone - t0), 64'd7);
    @(negedge clk);
    checkOutput("t6_sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
